chip8_mem_responder: RTL and testbench

// - Responder end of the chip8 memory read/ack + write-pulse protocol.
// - Serves two initiators, the GPU and the CPU, from one 4 KiB single-port byte RAM.
// - The framebuffer lives at 0x100..0x1FF.
// - Captures one-cycle request pulses and buffers writes.
// - Arbitrates one RAM access per cycle and returns read data with a one-cycle ack pulse.

---
 rtl/chip8_mem_responder_if.sv | 26 ++
 rtl/chip8_mem_responder.sv | 184 ++++++++++++++++++
 tb/tb_chip8_mem_responder.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/chip8_mem_responder_if.sv
// One initiator's memory port: read request/ack plus write pulse.
// The initiator (GPU or CPU) uses the master modport and the responder uses the slave modport.
interface chip8_mem_responder_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 8
) ();

   logic              mem_read;
   logic [ADDR_W-1:0] mem_read_addr;
   logic [DATA_W-1:0] mem_read_data;
   logic              mem_read_ack;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_write_addr;
   logic [DATA_W-1:0] mem_write_data;

   modport master (
      output mem_read, mem_read_addr, mem_write, mem_write_addr, mem_write_data,
      input  mem_read_data, mem_read_ack
   );

   modport slave (
      input  mem_read, mem_read_addr, mem_write, mem_write_addr, mem_write_data,
      output mem_read_data, mem_read_ack
   );

endinterface

// File: rtl/chip8_mem_responder.sv
// Serves the GPU and CPU memory ports from one single-port byte RAM with buffered writes.
// Optional CHIP8_FONT_ROM_EN overlays a read-only hex font at 0x000..0x04F.
module chip8_mem_responder #(
   parameter int ADDR_W        = 12,
   parameter int DATA_W        = 8,
   parameter int WR_FIFO_DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   chip8_mem_responder_if.slave    gpu,
   chip8_mem_responder_if.slave    cpu,
   output logic                    gpu_wr_overflow,
   output logic                    cpu_wr_overflow
);

   localparam int PTR_W = $clog2(WR_FIFO_DEPTH) + 1;
   localparam int IDX_W = PTR_W - 1;

   // Index 0 is the GPU port, index 1 the CPU port.
   logic [1:0]        rd_req;
   logic [1:0]        wr_req;
   logic [ADDR_W-1:0] rd_addr_in [2];
   logic [ADDR_W-1:0] wr_addr_in [2];
   logic [DATA_W-1:0] wr_data_in [2];

   logic [ADDR_W-1:0] fifo_addr [2][WR_FIFO_DEPTH];
   logic [DATA_W-1:0] fifo_data [2][WR_FIFO_DEPTH];
   logic [PTR_W-1:0]  wptr [2];
   logic [PTR_W-1:0]  rptr [2];
   logic [1:0]        fifo_empty;
   logic [1:0]        fifo_full;

   logic [1:0]        rd_pend;
   logic [ADDR_W-1:0] rd_pend_addr [2];
   logic [1:0]        rd_fire;
   logic [1:0]        ack_q;
   logic [DATA_W-1:0] rdata_q [2];
   logic [1:0]        ovf_q;

   logic [1:0]        grant_wr;
   logic [1:0]        grant_rd;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram [2**ADDR_W];
   logic [DATA_W-1:0] rd_word_q;
   logic              in_font;
   logic [DATA_W-1:0] font_byte;

   always_comb begin
      rd_req        = {cpu.mem_read, gpu.mem_read};
      wr_req        = {cpu.mem_write, gpu.mem_write};
      rd_addr_in[0] = gpu.mem_read_addr;
      rd_addr_in[1] = cpu.mem_read_addr;
      wr_addr_in[0] = gpu.mem_write_addr;
      wr_addr_in[1] = cpu.mem_write_addr;
      wr_data_in[0] = gpu.mem_write_data;
      wr_data_in[1] = cpu.mem_write_data;
   end

   // The extra pointer bit tells a full FIFO from an empty one.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         fifo_empty[p] = (wptr[p] == rptr[p]);
         fifo_full[p]  = (wptr[p][IDX_W] != rptr[p][IDX_W]) &&
                         (wptr[p][IDX_W-1:0] == rptr[p][IDX_W-1:0]);
      end
   end

   // Reads wait until both write FIFOs drain, so a read always sees earlier writes from either port.
   always_comb begin
      grant_wr = 2'b00;
      grant_rd = 2'b00;
      if (!fifo_empty[0])
         grant_wr[0] = 1'b1;
      else if (!fifo_empty[1])
         grant_wr[1] = 1'b1;
      else if (rd_pend[0])
         grant_rd[0] = 1'b1;
      else if (rd_pend[1])
         grant_rd[1] = 1'b1;
   end

   always_comb begin
      ram_wdata = '0;
      if (grant_wr[0]) begin
         ram_addr  = fifo_addr[0][rptr[0][IDX_W-1:0]];
         ram_wdata = fifo_data[0][rptr[0][IDX_W-1:0]];
      end else if (grant_wr[1]) begin
         ram_addr  = fifo_addr[1][rptr[1][IDX_W-1:0]];
         ram_wdata = fifo_data[1][rptr[1][IDX_W-1:0]];
      end else if (grant_rd[0]) begin
         ram_addr  = rd_pend_addr[0];
      end else begin
         ram_addr  = rd_pend_addr[1];
      end
   end

`ifdef CHIP8_FONT_ROM_EN
   localparam logic [0:639] FONT = {
      8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,  8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
      8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
      8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,  8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
      8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
      8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
      8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,  8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
      8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,  8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
      8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
   };

   always_comb begin
      in_font   = (ram_addr < ADDR_W'(80));
      font_byte = '0;
      if (in_font)
         font_byte = DATA_W'(FONT[{ram_addr[6:0], 3'b000} +: 8]);
   end
`else
   assign in_font   = 1'b0;
   assign font_byte = '0;
`endif

   // Writes into the font window still use their grant slot but never reach the RAM.
   assign ram_we = (grant_wr[0] | grant_wr[1]) & ~in_font;

   always_ff @(posedge clk) begin
      if (ram_we)
         ram[ram_addr] <= ram_wdata;
      rd_word_q <= in_font ? font_byte : ram[ram_addr];
   end

   always_ff @(posedge clk) begin
      for (int p = 0; p < 2; p++) begin
         if (wr_req[p] && !fifo_full[p]) begin
            fifo_addr[p][wptr[p][IDX_W-1:0]] <= wr_addr_in[p];
            fifo_data[p][wptr[p][IDX_W-1:0]] <= wr_data_in[p];
         end
      end
   end

   // A read pulse landing on the grant edge replaces the address and voids that grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int p = 0; p < 2; p++) begin
            wptr[p]         <= '0;
            rptr[p]         <= '0;
            rd_pend_addr[p] <= '0;
            rdata_q[p]      <= '0;
         end
         rd_pend <= 2'b00;
         rd_fire <= 2'b00;
         ack_q   <= 2'b00;
         ovf_q   <= 2'b00;
      end else begin
         for (int p = 0; p < 2; p++) begin
            if (wr_req[p]) begin
               if (!fifo_full[p])
                  wptr[p] <= wptr[p] + PTR_W'(1);
               else
                  ovf_q[p] <= 1'b1;
            end
            if (grant_wr[p])
               rptr[p] <= rptr[p] + PTR_W'(1);
            if (rd_req[p]) begin
               rd_pend[p]      <= 1'b1;
               rd_pend_addr[p] <= rd_addr_in[p];
            end else if (grant_rd[p]) begin
               rd_pend[p] <= 1'b0;
            end
            rd_fire[p] <= grant_rd[p] & ~rd_req[p];
            ack_q[p]   <= rd_fire[p];
            if (rd_fire[p])
               rdata_q[p] <= rd_word_q;
         end
      end
   end

   assign gpu.mem_read_ack  = ack_q[0];
   assign cpu.mem_read_ack  = ack_q[1];
   assign gpu.mem_read_data = rdata_q[0];
   assign cpu.mem_read_data = rdata_q[1];
   assign gpu_wr_overflow   = ovf_q[0];
   assign cpu_wr_overflow   = ovf_q[1];

endmodule

// File: tb/tb_chip8_mem_responder.sv
// Directed self-checking bench for chip8_mem_responder; expectations are hand-computed.
// Builds with or without CHIP8_FONT_ROM_EN.
module tb_chip8_mem_responder;

   logic clk;
   logic rst_n;
   logic gpu_wr_overflow;
   logic cpu_wr_overflow;
   int   errorCount;
   int   checkCount;

   chip8_mem_responder_if #(.ADDR_W(12), .DATA_W(8)) gpu_bus ();
   chip8_mem_responder_if #(.ADDR_W(12), .DATA_W(8)) cpu_bus ();

   chip8_mem_responder #(.ADDR_W(12), .DATA_W(8), .WR_FIFO_DEPTH(4)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .gpu             (gpu_bus),
      .cpu             (cpu_bus),
      .gpu_wr_overflow (gpu_wr_overflow),
      .cpu_wr_overflow (cpu_wr_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Outputs are sampled 1 ns after the rising edge, away from the edge itself.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
      end
   endtask

   // Lets the edge capture whatever pulses are set up, then drops all pulses.
   task automatic applyStimulus();
      step();
      gpu_bus.mem_read  = 1'b0;
      gpu_bus.mem_write = 1'b0;
      cpu_bus.mem_read  = 1'b0;
      cpu_bus.mem_write = 1'b0;
   endtask

   task automatic writePort(input bit useCpu, input logic [11:0] addr, input logic [7:0] data);
      if (useCpu) begin
         cpu_bus.mem_write = 1'b1; cpu_bus.mem_write_addr = addr; cpu_bus.mem_write_data = data;
      end else begin
         gpu_bus.mem_write = 1'b1; gpu_bus.mem_write_addr = addr; gpu_bus.mem_write_data = data;
      end
      applyStimulus();
      repeat (3) step();
   endtask

   task automatic readPort(input bit useCpu, input logic [11:0] addr, input logic [7:0] expData, input string tag);
      int         acks;
      logic [7:0] got;
      acks = 0;
      got  = 8'h00;
      if (useCpu) begin
         cpu_bus.mem_read = 1'b1; cpu_bus.mem_read_addr = addr;
      end else begin
         gpu_bus.mem_read = 1'b1; gpu_bus.mem_read_addr = addr;
      end
      applyStimulus();
      for (int i = 0; i < 8; i++) begin
         step();
         if (useCpu ? cpu_bus.mem_read_ack : gpu_bus.mem_read_ack) begin
            acks++;
            got = useCpu ? cpu_bus.mem_read_data : gpu_bus.mem_read_data;
         end
      end
      checkOutput({tag, " acks"}, acks, 1);
      checkOutput({tag, " data"}, got, expData);
   endtask

   initial begin
      int gpuAcks;
      int cpuAcks;
      errorCount = 0;
      checkCount = 0;
      rst_n = 1'b0;
      gpu_bus.mem_read = 1'b0; gpu_bus.mem_read_addr = '0;
      gpu_bus.mem_write = 1'b0; gpu_bus.mem_write_addr = '0; gpu_bus.mem_write_data = '0;
      cpu_bus.mem_read = 1'b0; cpu_bus.mem_read_addr = '0;
      cpu_bus.mem_write = 1'b0; cpu_bus.mem_write_addr = '0; cpu_bus.mem_write_data = '0;
      repeat (3) step();
      checkOutput("reset gpu ack", gpu_bus.mem_read_ack, 0);
      checkOutput("reset cpu ack", cpu_bus.mem_read_ack, 0);
      checkOutput("reset gpu data", gpu_bus.mem_read_data, 0);
      checkOutput("reset cpu data", cpu_bus.mem_read_data, 0);
      checkOutput("reset gpu ovf", gpu_wr_overflow, 0);
      checkOutput("reset cpu ovf", cpu_wr_overflow, 0);
      rst_n = 1'b1;
      step();

      $display("[TB] write-then-read");
      gpu_bus.mem_write = 1'b1; gpu_bus.mem_write_addr = 12'h105; gpu_bus.mem_write_data = 8'hA5;
      applyStimulus();
      gpu_bus.mem_read = 1'b1; gpu_bus.mem_read_addr = 12'h105;
      applyStimulus();
      step();
      checkOutput("wr-rd ack early", gpu_bus.mem_read_ack, 0);
      step();
      checkOutput("wr-rd ack", gpu_bus.mem_read_ack, 1);
      checkOutput("wr-rd data", gpu_bus.mem_read_data, 8'hA5);
      step();
      checkOutput("wr-rd ack single", gpu_bus.mem_read_ack, 0);

      $display("[TB] simultaneous reads");
      gpu_bus.mem_write = 1'b1; gpu_bus.mem_write_addr = 12'h200; gpu_bus.mem_write_data = 8'h11;
      cpu_bus.mem_write = 1'b1; cpu_bus.mem_write_addr = 12'h300; cpu_bus.mem_write_data = 8'h22;
      applyStimulus();
      repeat (4) step();
      gpu_bus.mem_read = 1'b1; gpu_bus.mem_read_addr = 12'h200;
      cpu_bus.mem_read = 1'b1; cpu_bus.mem_read_addr = 12'h300;
      applyStimulus();
      step();
      checkOutput("sim E1 gpu ack", gpu_bus.mem_read_ack, 0);
      checkOutput("sim E1 cpu ack", cpu_bus.mem_read_ack, 0);
      step();
      checkOutput("sim E2 gpu ack", gpu_bus.mem_read_ack, 1);
      checkOutput("sim E2 gpu data", gpu_bus.mem_read_data, 8'h11);
      checkOutput("sim E2 cpu ack", cpu_bus.mem_read_ack, 0);
      step();
      checkOutput("sim E3 gpu ack", gpu_bus.mem_read_ack, 0);
      checkOutput("sim E3 cpu ack", cpu_bus.mem_read_ack, 1);
      checkOutput("sim E3 cpu data", cpu_bus.mem_read_data, 8'h22);
      step();
      checkOutput("sim E4 cpu ack", cpu_bus.mem_read_ack, 0);

      $display("[TB] write overflow");
      writePort(1'b1, 12'h314, 8'h5A);
      for (int i = 0; i < 5; i++) begin
         gpu_bus.mem_write = 1'b1; gpu_bus.mem_write_addr = 12'h110 + 12'(i); gpu_bus.mem_write_data = 8'h30 + 8'(i);
         cpu_bus.mem_write = 1'b1; cpu_bus.mem_write_addr = 12'h310 + 12'(i); cpu_bus.mem_write_data = 8'h40 + 8'(i);
         applyStimulus();
         if (i == 3) checkOutput("ovf after 4th cpu", cpu_wr_overflow, 0);
      end
      checkOutput("ovf after 5th cpu", cpu_wr_overflow, 1);
      checkOutput("ovf gpu clear", gpu_wr_overflow, 0);
      repeat (10) step();
      readPort(1'b1, 12'h310, 8'h40, "ovf cpu0");
      readPort(1'b1, 12'h311, 8'h41, "ovf cpu1");
      readPort(1'b0, 12'h312, 8'h42, "ovf cpu2");
      readPort(1'b0, 12'h313, 8'h43, "ovf cpu3");
      readPort(1'b1, 12'h314, 8'h5A, "ovf cpu dropped");
      readPort(1'b0, 12'h114, 8'h34, "ovf gpu4");
      checkOutput("ovf cpu sticky", cpu_wr_overflow, 1);

      $display("[TB] font window");
`ifdef CHIP8_FONT_ROM_EN
      readPort(1'b0, 12'h000, 8'hF0, "font 000");
      readPort(1'b1, 12'h005, 8'h20, "font 005");
      readPort(1'b1, 12'h04F, 8'h80, "font 04F");
      writePort(1'b0, 12'h000, 8'h00);
      readPort(1'b0, 12'h000, 8'hF0, "font after wr");
`else
      writePort(1'b0, 12'h000, 8'h00);
      readPort(1'b0, 12'h000, 8'h00, "plain 000");
      writePort(1'b1, 12'h04F, 8'hC3);
      readPort(1'b0, 12'h04F, 8'hC3, "plain 04F");
`endif

      $display("[TB] replaced read");
      writePort(1'b0, 12'h010, 8'h66);
      writePort(1'b1, 12'h020, 8'h77);
      gpu_bus.mem_read = 1'b1; gpu_bus.mem_read_addr = 12'h010;
      applyStimulus();
      gpu_bus.mem_read = 1'b1; gpu_bus.mem_read_addr = 12'h020;
      applyStimulus();
      gpuAcks = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (gpu_bus.mem_read_ack) begin
            gpuAcks++;
`ifdef CHIP8_FONT_ROM_EN
            checkOutput("replaced data", gpu_bus.mem_read_data, 8'hF0);
`else
            checkOutput("replaced data", gpu_bus.mem_read_data, 8'h77);
`endif
         end
      end
      checkOutput("replaced acks", gpuAcks, 1);

      $display("[TB] reset mid-read");
      cpu_bus.mem_read = 1'b1; cpu_bus.mem_read_addr = 12'h300;
      applyStimulus();
      rst_n = 1'b0;
      #2;
      checkOutput("rst gpu ack", gpu_bus.mem_read_ack, 0);
      checkOutput("rst cpu ack", cpu_bus.mem_read_ack, 0);
      checkOutput("rst gpu data", gpu_bus.mem_read_data, 0);
      checkOutput("rst cpu data", cpu_bus.mem_read_data, 0);
      checkOutput("rst gpu ovf", gpu_wr_overflow, 0);
      checkOutput("rst cpu ovf", cpu_wr_overflow, 0);
      repeat (2) step();
      rst_n = 1'b1;
      gpuAcks = 0;
      cpuAcks = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (gpu_bus.mem_read_ack) gpuAcks++;
         if (cpu_bus.mem_read_ack) cpuAcks++;
      end
      checkOutput("post-rst gpu acks", gpuAcks, 0);
      checkOutput("post-rst cpu acks", cpuAcks, 0);
      checkOutput("post-rst cpu data", cpu_bus.mem_read_data, 0);
      checkOutput("post-rst cpu ovf", cpu_wr_overflow, 0);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
